// File: rtl/stg_trap_pkg.sv
// stg_trap_pkg: cause codes, FSM states and default vector geometry for the trap-entry controller
package stg_trap_pkg;
  localparam int HBIT_ADDR = 47;
  localparam int HBIT_CAUSE = 7;
  localparam logic [HBIT_ADDR:0] DEF_VEC_BASE = 48'h0000_0100;
  localparam int DEF_VEC_STRIDE = 16;
  typedef enum logic [2:0] {
    ST_USER, ST_ENTER, ST_REDIR, ST_KERNEL, ST_HALT
  } state_t;
  typedef enum logic [2:0] {
    C_NONE = 3'd0, C_SYSCALL = 3'd1, C_ILLEGAL = 3'd2, C_IRQ = 3'd3, C_DOUBLE = 3'd4
  } cause_t;
endpackage

// File: rtl/stg_trap_prio.sv
// stg_trap_prio: fixed-priority trap encoder, ILLEGAL > SYSCALL > IRQ
module stg_trap_prio
  import stg_trap_pkg::*;
(
  input  logic   illegal,
  input  logic   syscall,
  input  logic   irq,
  output logic   valid,
  output cause_t cause
);
  assign valid = illegal | syscall | irq;
  assign cause = illegal ? C_ILLEGAL : syscall ? C_SYSCALL : irq ? C_IRQ : C_NONE;
endmodule

// File: rtl/stg_trap.sv
// stg_trap: trap-entry FSM (save LR, record cause, flush, redirect to vector, kernel mode)
// Build option TRAP_IRQ_EN enables the external interrupt path; without it iw_irq is ignored.
module stg_trap
  import stg_trap_pkg::*;
#(
  parameter int ADDR_W = HBIT_ADDR + 1,
  parameter int CAUSE_W = HBIT_CAUSE + 1,
  parameter logic [ADDR_W-1:0] VEC_BASE = ADDR_W'(DEF_VEC_BASE),
  parameter int VEC_STRIDE = DEF_VEC_STRIDE
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic               iw_ex_valid,
  input  logic [ADDR_W-1:0]  iw_ex_pc,
  input  logic               iw_syscall,
  input  logic               iw_illegal,
  input  logic               iw_irq,
  input  logic               iw_kret,
  output logic               ow_kmode,
  output logic               ow_lr_we,
  output logic [ADDR_W-1:0]  ow_lr_val,
  output logic               ow_cause_we,
  output logic [CAUSE_W-1:0] ow_cause,
  output logic               ow_flush,
  output logic               ow_stall,
  output logic               ow_redirect,
  output logic [ADDR_W-1:0]  ow_redirect_pc,
  output logic               ow_irq_ack,
  output logic               ow_halted
);
  state_t state, state_n;
  cause_t cause_q, cause_n, p_cause;
  logic [ADDR_W-1:0] ret_q, ret_n, vec;
  logic p_valid, irq_m, trap, dbl;
`ifdef TRAP_IRQ_EN
  assign irq_m = iw_irq;
`else
  assign irq_m = iw_irq & 1'b0;
`endif
  stg_trap_prio u_prio (
    .illegal(iw_illegal),
    .syscall(iw_syscall),
    .irq    (irq_m),
    .valid  (p_valid),
    .cause  (p_cause)
  );
  assign trap = iw_ex_valid & p_valid;
  assign dbl = iw_ex_valid & (iw_illegal | iw_syscall);
  assign vec = VEC_BASE + ADDR_W'(cause_q) * ADDR_W'(VEC_STRIDE);
  always_ff @(posedge iw_clk or posedge iw_rst)
    if (iw_rst) begin
      state <= ST_USER;
      cause_q <= C_NONE;
      ret_q <= '0;
    end else begin
      state <= state_n;
      cause_q <= cause_n;
      ret_q <= ret_n;
    end
  // A double fault reuses ENTER with cause DOUBLE but keeps the saved LR.
  always_comb begin
    state_n = state;
    cause_n = cause_q;
    ret_n = ret_q;
    case (state)
      ST_USER: if (trap) begin
        state_n = ST_ENTER;
        cause_n = p_cause;
        ret_n = (p_cause == C_SYSCALL) ? iw_ex_pc + 1'b1 : iw_ex_pc;
      end
      ST_ENTER: state_n = (cause_q == C_DOUBLE) ? ST_HALT : ST_REDIR;
      ST_REDIR: state_n = ST_KERNEL;
      ST_KERNEL: if (iw_kret) state_n = ST_USER;
        else if (dbl) begin
          state_n = ST_ENTER;
          cause_n = C_DOUBLE;
        end
      default: state_n = ST_HALT;
    endcase
  end
  always_comb begin
    ow_kmode = (state == ST_REDIR) || (state == ST_KERNEL) || (state == ST_HALT) ||
               (state == ST_ENTER && cause_q == C_DOUBLE);
    ow_lr_we = (state == ST_ENTER) && (cause_q != C_DOUBLE);
    ow_lr_val = ret_q;
    ow_cause_we = state == ST_ENTER;
    ow_cause = CAUSE_W'(cause_q);
    ow_flush = (state == ST_ENTER) || (state == ST_REDIR);
    ow_stall = (state == ST_ENTER) || (state == ST_HALT);
    ow_redirect = state == ST_REDIR;
    ow_redirect_pc = (state == ST_REDIR) ? vec : '0;
`ifdef TRAP_IRQ_EN
    ow_irq_ack = (state == ST_ENTER) && (cause_q == C_IRQ);
`else
    ow_irq_ack = 1'b0;
`endif
    ow_halted = state == ST_HALT;
  end
endmodule

// File: tb/tb_stg_trap.sv
// tb_stg_trap: directed self-checking bench for the trap-entry controller
module tb_stg_trap;
  logic clk = 0, rst = 1, ex_valid = 0, syscall = 0, illegal = 0, irq = 0, kret = 0;
  logic [47:0] ex_pc = '0;
  logic kmode, lr_we, cause_we, flush, stall, redirect, irq_ack, halted;
  logic [47:0] lr_val, redirect_pc;
  logic [7:0] cause;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  stg_trap dut (
    .iw_clk(clk), .iw_rst(rst), .iw_ex_valid(ex_valid), .iw_ex_pc(ex_pc),
    .iw_syscall(syscall), .iw_illegal(illegal), .iw_irq(irq), .iw_kret(kret),
    .ow_kmode(kmode), .ow_lr_we(lr_we), .ow_lr_val(lr_val), .ow_cause_we(cause_we),
    .ow_cause(cause), .ow_flush(flush), .ow_stall(stall), .ow_redirect(redirect),
    .ow_redirect_pc(redirect_pc), .ow_irq_ack(irq_ack), .ow_halted(halted)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic idle;
    ex_valid = 0; syscall = 0; illegal = 0; irq = 0; kret = 0;
  endtask
  initial begin
    #3;
    chk("rst_kmode", 64'(kmode), 64'd0);
    chk("rst_lr_val", 64'(lr_val), 64'd0);
    chk("rst_cause", 64'(cause), 64'd0);
    chk("rst_redir_pc", 64'(redirect_pc), 64'd0);
    chk("rst_ctl", 64'({lr_we, cause_we, flush, stall, redirect, irq_ack, halted}), 64'd0);
    tick; tick;
    rst = 0;
    kret = 1; syscall = 1; ex_pc = 48'h200;
    tick;
    chk("user_kret_nop", 64'({kmode, flush, lr_we}), 64'd0);
    kret = 0; ex_valid = 1;
    tick;
    idle;
    chk("sc_lr_we", 64'(lr_we), 64'd1);
    chk("sc_lr_val", 64'(lr_val), 64'h201);
    chk("sc_cause", 64'(cause), 64'd1);
    chk("sc_enter_ctl", 64'({cause_we, flush, stall, redirect, kmode}), 64'b11100);
    illegal = 1; ex_valid = 1;
    tick;
    idle;
    chk("sc_redirect", 64'(redirect), 64'd1);
    chk("sc_redir_pc", 64'(redirect_pc), 64'h110);
    chk("sc_redir_ctl", 64'({kmode, flush, lr_we, stall}), 64'b1100);
    tick;
    chk("kern_ctl", 64'({kmode, flush, redirect, halted}), 64'b1000);
    irq = 1; ex_valid = 1;
    tick; tick;
    chk("kern_irq_mask", 64'({kmode, lr_we, flush, cause_we}), 64'b1000);
    idle; kret = 1;
    tick;
    idle;
    chk("kret_exit", 64'(kmode), 64'd0);
    ex_valid = 1; illegal = 1; irq = 1; ex_pc = 48'h300;
    tick;
    idle;
    chk("ill_cause", 64'(cause), 64'd2);
    chk("ill_lr_val", 64'(lr_val), 64'h300);
    chk("ill_irq_ack", 64'(irq_ack), 64'd0);
    tick;
    chk("ill_redir_pc", 64'(redirect_pc), 64'h120);
    tick;
    kret = 1;
    tick;
    idle;
    chk("ill_exit", 64'(kmode), 64'd0);
    ex_valid = 1; irq = 1; ex_pc = 48'h400;
    tick;
    idle;
`ifdef TRAP_IRQ_EN
    chk("irq_cause", 64'(cause), 64'd3);
    chk("irq_ack", 64'(irq_ack), 64'd1);
    chk("irq_lr_val", 64'(lr_val), 64'h400);
    tick;
    chk("irq_ack_pulse", 64'(irq_ack), 64'd0);
    chk("irq_redir_pc", 64'(redirect_pc), 64'h130);
    tick;
    kret = 1;
    tick;
    idle;
    chk("irq_exit", 64'(kmode), 64'd0);
`else
    chk("irq_off_enter", 64'({lr_we, cause_we, flush, irq_ack}), 64'd0);
    tick;
    chk("irq_off_redir", 64'({redirect, kmode, irq_ack}), 64'd0);
`endif
    syscall = 1; ex_valid = 0; ex_pc = 48'h500;
    tick;
    chk("no_valid_nop", 64'({lr_we, flush, kmode}), 64'd0);
    ex_valid = 1;
    tick;
    idle;
    chk("sc2_lr_val", 64'(lr_val), 64'h501);
    tick; tick;
    ex_valid = 1; syscall = 1;
    tick;
    idle;
    chk("dbl_cause", 64'(cause), 64'd4);
    chk("dbl_ctl", 64'({lr_we, cause_we, flush, kmode}), 64'b0111);
    chk("dbl_lr_keep", 64'(lr_val), 64'h501);
    tick;
    kret = 1;
    chk("halt_ctl", 64'({halted, stall, kmode, lr_we, flush}), 64'b11100);
    tick; tick;
    idle;
    chk("halt_sticky", 64'({halted, kmode}), 64'b11);
    #3 rst = 1;
    #1;
    chk("halt_async_rst", 64'({halted, kmode, stall, flush, lr_we, cause_we}), 64'd0);
    chk("halt_rst_cause", 64'(cause), 64'd0);
    tick;
    rst = 0;
    ex_valid = 1; syscall = 1; ex_pc = 48'hFFFF_FFFF_FFFF;
    tick;
    idle;
    chk("wrap_lr_val", 64'(lr_val), 64'd0);
    chk("wrap_enter_redir", 64'(redirect), 64'd0);
    #1 rst = 1;
    #1;
    chk("enter_rst_lr", 64'({lr_we, lr_val}), 64'd0);
    tick;
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      chk("enter_rst_no_redir", 64'({redirect, kmode}), 64'd0);
      tick;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stg_trap.md
Name: stg_trap

Overview:
- Trap-entry controller. It is the initiating side of the KRET return protocol: it saves the return PC into LR, records a cause, enters kernel mode, flushes the pipeline and redirects fetch to a vector.
- KRET, executed in stg_ex, is the matching exit path. This block observes the taken KRET to leave kernel mode.
- It sits beside stg_ex and drives the pipeline-wide flush/stall and the fetch redirect.

Parameters:
- ADDR_W, 48, address/PC width.
- CAUSE_W, 8, cause register width.
- VEC_BASE, 48'h0000_0100, trap vector table base.
- VEC_STRIDE, 16, address distance between vectors.

Ports:
- iw_clk  in  1  clock.
- iw_rst  in  1  asynchronous, active-high reset.
- iw_ex_valid  in  1  EX holds a real (not flushed) instruction.
- iw_ex_pc  in  ADDR_W  PC of the EX instruction.
- iw_syscall  in  1  EX instruction is KCALL.
- iw_illegal  in  1  EX instruction failed decode.
- iw_irq  in  1  external interrupt request, level.
- iw_kret  in  1  EX is executing KRET and stg_ex asserted branch_taken.
- ow_kmode  out  1  kernel mode flag.
- ow_lr_we  out  1  LR write strobe.
- ow_lr_val  out  ADDR_W  return address written to LR.
- ow_cause_we  out  1  cause SR write strobe.
- ow_cause  out  CAUSE_W  cause value.
- ow_flush  out  1  squash IF..EX.
- ow_stall  out  1  hold the PC/fetch stage.
- ow_redirect  out  1  load fetch PC.
- ow_redirect_pc  out  ADDR_W  vector address.
- ow_irq_ack  out  1  one-cycle interrupt acknowledge.
- ow_halted  out  1  double-fault lock.

Behaviour:
- Reset (asynchronous): state USER; all outputs 0; ow_lr_val, ow_redirect_pc and ow_cause are 0.
- States: USER, ENTER, REDIR, KERNEL, HALT.
- Trap qualification (USER only): a trap is taken when iw_ex_valid and any of iw_illegal, iw_syscall or iw_irq is set.
  - Priority: ILLEGAL > SYSCALL > IRQ.
  - The cause, return PC and vector are latched at the sampling edge.
- Return address:
  - SYSCALL returns to iw_ex_pc+1. KCALL completes; ADDR_W wrap, so all-ones+1 gives 0.
  - ILLEGAL and IRQ return to iw_ex_pc. The EX instruction is squashed and re-executed after KRET.
- USER -> ENTER at the edge where a trap qualifies. Cycle N request, cycle N+1 in ENTER.
- ENTER, exactly one cycle:
  - ow_lr_we=1, ow_lr_val=return address.
  - ow_cause_we=1, ow_cause=latched cause.
  - ow_flush=1, ow_stall=1.
  - ow_irq_ack=1 if the cause is IRQ.
  - Next state REDIR.
- REDIR, one cycle:
  - ow_redirect=1, ow_redirect_pc=VEC_BASE + cause*VEC_STRIDE, ow_flush=1.
  - ow_kmode=1.
  - Next state KERNEL.
- KERNEL:
  - ow_kmode=1; iw_irq is ignored (masked).
  - iw_kret sampled -> USER, with ow_kmode=0 from the next cycle. Fetch redirect on KRET is owned by stg_ex, not this block.
  - iw_illegal or iw_syscall with iw_ex_valid -> HALT, with an ENTER-like cycle: cause=DOUBLE, ow_flush=1. LR is NOT overwritten.
  - If iw_kret coincides with a trap input, iw_kret wins.
- HALT:
  - ow_halted=1, ow_stall=1, ow_kmode=1.
  - Exits only on reset.
- Simultaneous inputs in USER:
  - iw_kret in USER is ignored.
  - Trap inputs while in ENTER or REDIR are ignored, since the pipeline is being flushed.
- Reset mid-ENTER or mid-REDIR aborts to USER; no partial LR write is held.
- Cause encoding (CAUSE_W): SYSCALL=1, ILLEGAL=2, IRQ=3, DOUBLE=4. Vector offset uses cause*VEC_STRIDE, zero-extended to ADDR_W.

Optional Feature:
- Macro TRAP_IRQ_EN.
- Defined: the IRQ path exists as described.
- Undefined: iw_irq is ignored entirely, ow_irq_ack is tied 0, and CAUSE_IRQ is never produced. All other timing is unchanged.

Decomposition:
- src/trap.vh holds:
  - CAUSE_SYSCALL / ILLEGAL / IRQ / DOUBLE.
  - State encodings.
  - HBIT_CAUSE.
  - Default VEC_BASE/VEC_STRIDE.
- The address width comes from sizes.vh (HBIT_ADDR).
- One natural sub-module, trap_prio: a combinational priority encoder from {illegal, syscall, irq} to {valid, cause}. The FSM, return-PC latch and vector math stay in stg_trap.

Test Plan:
- KCALL at iw_ex_pc=48'h0000_0200 -> next cycle: ow_lr_we=1, ow_lr_val=48'h0000_0201, ow_cause=1, ow_flush=1. Cycle after: ow_redirect=1, ow_redirect_pc=48'h0000_0110, ow_kmode=1.
- Illegal and IRQ together at pc 48'h0000_0300 -> cause=2, ow_lr_val=48'h0000_0300, ow_redirect_pc=48'h0000_0120, ow_irq_ack=0.
- IRQ alone at pc 48'h0000_0400 (TRAP_IRQ_EN) -> cause=3, ow_irq_ack pulses 1 cycle, ow_redirect_pc=48'h0000_0130. Without the macro: no response.
- In KERNEL: iw_irq held -> no trap. Then iw_kret=1 -> ow_kmode=0 next cycle, and a subsequent IRQ is taken.
- Syscall while in KERNEL -> cause=4, ow_lr_we stays 0, ow_halted=1 persistently. Async reset mid-HALT -> all outputs 0 immediately.
- Syscall at pc 48'hFFFF_FFFF_FFFF -> ow_lr_val=0. Reset asserted during ENTER -> ow_redirect never asserted.
